l2_cache_control: RTL and testbench

//  Sequencing FSM for the 4-way write-back L2 cache datapath; sits between the L1 side
//  (mem_read/mem_write/mem_resp) and physical memory (pmem_read/pmem_write/pmem_resp).

---
 rtl/lc3b_types.sv | 11 +
 rtl/l2_perf_counter.sv | 31 +++
 rtl/l2_cache_control.sv | 155 +++++++++++++++
 tb/tb_l2_cache_control.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared types for the L2 cache control slice.
//   l2_ctrl_state_t : sequencing state of the L2 control FSM.
package lc3b_types;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH
    } l2_ctrl_state_t;

endpackage

// File: rtl/l2_perf_counter.sv
// Saturating performance counter.
//   clk   : system clock
//   reset : synchronous active-high reset, highest priority
//   clear : synchronous clear, priority over inc
//   inc   : count one event this cycle
//   count : current value, holds at all-ones instead of wrapping
module l2_perf_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/l2_cache_control.sv
// Sequencing FSM for the 4-way write-back L2 cache datapath.
// L1 side  : mem_read, mem_write (held until mem_resp), mem_resp (1-cycle done pulse).
// Memory   : pmem_read / pmem_write (held until pmem_resp), pmem_resp.
// Datapath : cache_hit, dirtyout in; write_enable, cache_allocate, datain_mux_sel,
//            valid_in, dirty_datain, addr_reg_load, evict_allocate, pmem_address_sel out.
// Counters : hit_count, miss_count, wb_count (saturating), cleared by cnt_clear.
module l2_cache_control
    import lc3b_types::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    input  logic                 cache_hit,
    input  logic                 dirtyout,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    output logic                 write_enable,
    output logic                 cache_allocate,
    output logic                 datain_mux_sel,
    output logic                 valid_in,
    output logic                 dirty_datain,
    output logic                 addr_reg_load,
    output logic                 evict_allocate,
    output logic                 pmem_address_sel,
    input  logic                 cnt_clear,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);

    l2_ctrl_state_t state_q, state_d;
    logic           req;
    logic           hit_inc, miss_inc, wb_inc;

    // A simultaneous read and write is served as a write; both are just "a request" here.
    assign req = mem_read | mem_write;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req && !cache_hit) begin
                    state_d = dirtyout ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                if (pmem_resp) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (pmem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic; everything is forced low while reset is asserted so a reset that lands
    // mid-miss can neither strobe the arrays nor keep a memory request alive.
    always_comb begin
        mem_resp         = 1'b0;
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        write_enable     = 1'b0;
        cache_allocate   = 1'b0;
        datain_mux_sel   = 1'b0;
        valid_in         = 1'b0;
        dirty_datain     = 1'b0;
        addr_reg_load    = 1'b0;
        evict_allocate   = 1'b0;
        pmem_address_sel = 1'b0;
        hit_inc          = 1'b0;
        miss_inc         = 1'b0;
        wb_inc           = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (req && cache_hit) begin
                        mem_resp = 1'b1;
                        hit_inc  = 1'b1;
                        if (mem_write) begin
                            write_enable   = 1'b1;
                            datain_mux_sel = 1'b1;
                            valid_in       = 1'b1;
                            dirty_datain   = 1'b1;
                        end
                    end else if (req) begin
                        addr_reg_load = 1'b1;
                        miss_inc      = 1'b1;
                    end
                end
                WRITEBACK: begin
                    pmem_write       = 1'b1;
                    pmem_address_sel = 1'b1;
                    evict_allocate   = 1'b1;
                    wb_inc           = pmem_resp;
                end
                FETCH: begin
                    pmem_read      = 1'b1;
                    evict_allocate = 1'b1;
                    if (pmem_resp) begin
                        // Fill the LRU way with a clean line; the retried request that
                        // follows will dirty it if it is a write.
                        write_enable   = 1'b1;
                        cache_allocate = 1'b1;
                        valid_in       = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    l2_perf_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (hit_inc),
        .count (hit_count)
    );

    l2_perf_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (miss_inc),
        .count (miss_count)
    );

    l2_perf_counter #(.WIDTH(CNT_WIDTH)) u_wb_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (wb_inc),
        .count (wb_count)
    );

endmodule

// File: tb/tb_l2_cache_control.sv
// Self-checking bench for l2_cache_control: table of single-request IDLE vectors plus
// hand-written miss, reset and counter-saturation sequences.
module tb_l2_cache_control;

    logic        clk = 1'b0;
    logic        reset, mem_read, mem_write, cache_hit, dirtyout, pmem_resp, cnt_clear;
    logic        mem_resp, pmem_read, pmem_write, write_enable, cache_allocate;
    logic        datain_mux_sel, valid_in, dirty_datain, addr_reg_load, evict_allocate;
    logic        pmem_address_sel;
    logic [15:0] hit_count, miss_count, wb_count;

    always #5 clk = ~clk;

    l2_cache_control #(.CNT_WIDTH(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_resp         (mem_resp),
        .cache_hit        (cache_hit),
        .dirtyout         (dirtyout),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_resp        (pmem_resp),
        .write_enable     (write_enable),
        .cache_allocate   (cache_allocate),
        .datain_mux_sel   (datain_mux_sel),
        .valid_in         (valid_in),
        .dirty_datain     (dirty_datain),
        .addr_reg_load    (addr_reg_load),
        .evict_allocate   (evict_allocate),
        .pmem_address_sel (pmem_address_sel),
        .cnt_clear        (cnt_clear),
        .hit_count        (hit_count),
        .miss_count       (miss_count),
        .wb_count         (wb_count)
    );

    int checks = 0;
    int passed = 0;

    // Output bundle order:
    // {mem_resp, pmem_read, pmem_write, write_enable, cache_allocate, datain_mux_sel,
    //  valid_in, dirty_datain, addr_reg_load, evict_allocate, pmem_address_sel}
    function automatic logic [10:0] o(input logic resp, prd, pwr, we, alloc, mux, vin, din,
                                      arl, ev, pas);
        return {resp, prd, pwr, we, alloc, mux, vin, din, arl, ev, pas};
    endfunction

    logic [10:0] o_none, o_rhit, o_whit, o_det, o_wb, o_fw, o_fr;

    typedef struct {
        string       name;
        logic [10:0] exp;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        string       name;
        logic        rd, wr, hit, dirty, presp;
        logic [10:0] exp1, exp2;
    } vec_t;
    vec_t vecs[10];

    // Caller is at posedge+1: drive inputs, queue the expectation, compare at negedge,
    // then advance to the next posedge+1.
    task automatic step(input string nm, input logic rst, rd, wr, hit, dirty, presp,
                        input logic [10:0] exp);
        sb_t         e;
        logic [10:0] act;
        reset     = rst;
        mem_read  = rd;
        mem_write = wr;
        cache_hit = hit;
        dirtyout  = dirty;
        pmem_resp = presp;
        sbq.push_back('{name: nm, exp: exp});
        @(negedge clk);
        act = {mem_resp, pmem_read, pmem_write, write_enable, cache_allocate, datain_mux_sel,
               valid_in, dirty_datain, addr_reg_load, evict_allocate, pmem_address_sel};
        checks++;
        if (sbq.size() == 0) begin
            $display("FAIL %s: scoreboard empty, got %b", nm, act);
        end else begin
            e = sbq.pop_front();
            if (act === e.exp) passed++;
            else $display("FAIL %s: outputs got %b expected %b", e.name, act, e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: count got %h expected %h", nm, act, exp);
    endtask

    task automatic do_reset(input string nm);
        step(nm, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, o_none);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        o_none = '0;
        o_rhit = o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        o_whit = o(1, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0);
        o_det  = o(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        o_wb   = o(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
        o_fw   = o(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        o_fr   = o(0, 1, 0, 1, 1, 0, 1, 0, 0, 1, 0);

        //          name          rd wr hit dty prs  cycle1  cycle2 (inputs held)
        vecs[0] = '{"idle_none",  0, 0, 0,  0,  0,   o_none, o_none};
        vecs[1] = '{"read_hit",   1, 0, 1,  0,  0,   o_rhit, o_rhit};
        vecs[2] = '{"write_hit",  0, 1, 1,  1,  0,   o_whit, o_whit};
        vecs[3] = '{"rw_hit",     1, 1, 1,  0,  0,   o_whit, o_whit};
        vecs[4] = '{"rd_miss_cl", 1, 0, 0,  0,  0,   o_det,  o_fw};
        vecs[5] = '{"rd_miss_dt", 1, 0, 0,  1,  0,   o_det,  o_wb};
        vecs[6] = '{"wr_miss_cl", 0, 1, 0,  0,  0,   o_det,  o_fw};
        vecs[7] = '{"presp_idle", 0, 0, 0,  0,  1,   o_none, o_none};
        vecs[8] = '{"hit_no_req", 0, 0, 1,  1,  0,   o_none, o_none};
        vecs[9] = '{"wr_miss_dt", 0, 1, 0,  1,  0,   o_det,  o_wb};

        reset = 1'b1; mem_read = 0; mem_write = 0; cache_hit = 0; dirtyout = 0;
        pmem_resp = 0; cnt_clear = 0;
        @(posedge clk); #1;
        do_reset("reset_outputs");
        check_cnt("reset_hit_cnt", hit_count, 16'h0);
        check_cnt("reset_miss_cnt", miss_count, 16'h0);
        check_cnt("reset_wb_cnt", wb_count, 16'h0);

        for (int i = 0; i < 10; i++) begin
            step({vecs[i].name, "_c1"}, 1'b0, vecs[i].rd, vecs[i].wr, vecs[i].hit,
                 vecs[i].dirty, vecs[i].presp, vecs[i].exp1);
            step({vecs[i].name, "_c2"}, 1'b0, vecs[i].rd, vecs[i].wr, vecs[i].hit,
                 vecs[i].dirty, vecs[i].presp, vecs[i].exp2);
            do_reset("vec_reset");
        end

        // Single read hit then idle: exactly one hit counted.
        step("t1_read_hit", 0, 1, 0, 1, 0, 0, o_rhit);
        step("t1_idle", 0, 0, 0, 0, 0, 0, o_none);
        check_cnt("t1_hit_cnt", hit_count, 16'd1);
        step("t2_write_hit", 0, 0, 1, 1, 0, 0, o_whit);
        step("t2_idle", 0, 0, 0, 0, 0, 0, o_none);
        check_cnt("t2_hit_cnt", hit_count, 16'd2);
        check_cnt("t2_miss_cnt", miss_count, 16'd0);
        do_reset("t3_reset");

        // Clean read miss, memory answers on the 5th fetch cycle.
        step("t3_detect", 0, 1, 0, 0, 0, 0, o_det);
        for (int i = 0; i < 4; i++) step("t3_fetch_wait", 0, 1, 0, 0, 0, 0, o_fw);
        step("t3_fetch_resp", 0, 1, 0, 0, 0, 1, o_fr);
        step("t3_rehit", 0, 1, 0, 1, 0, 0, o_rhit);
        step("t3_idle", 0, 0, 0, 0, 0, 0, o_none);
        check_cnt("t3_miss_cnt", miss_count, 16'd1);
        check_cnt("t3_hit_cnt", hit_count, 16'd1);
        check_cnt("t3_wb_cnt", wb_count, 16'd0);
        do_reset("t4_reset");

        // Dirty write miss; request drops mid-writeback and the fill still completes.
        step("t4_detect", 0, 0, 1, 0, 1, 0, o_det);
        step("t4_wb_wait", 0, 0, 1, 0, 1, 0, o_wb);
        step("t4_wb_drop", 0, 0, 0, 0, 1, 0, o_wb);
        step("t4_wb_resp", 0, 0, 1, 0, 1, 1, o_wb);
        check_cnt("t4_wb_cnt", wb_count, 16'd1);
        step("t4_fetch_wait", 0, 0, 1, 0, 1, 0, o_fw);
        step("t4_fetch_resp", 0, 0, 1, 0, 1, 1, o_fr);
        step("t4_rehit", 0, 0, 1, 1, 0, 0, o_whit);
        step("t4_idle", 0, 0, 0, 0, 0, 0, o_none);
        check_cnt("t4_miss_cnt", miss_count, 16'd1);
        check_cnt("t4_wb_cnt2", wb_count, 16'd1);
        check_cnt("t4_hit_cnt", hit_count, 16'd1);
        do_reset("t5_reset");

        // Reset lands during FETCH while memory responds: nothing may be strobed.
        step("t5_detect", 0, 1, 0, 0, 0, 0, o_det);
        step("t5_fetch", 0, 1, 0, 0, 0, 0, o_fw);
        step("t5_reset_in_fetch", 1, 1, 0, 0, 0, 1, o_none);
        step("t5_after_reset", 0, 0, 0, 0, 0, 1, o_none);
        step("t5_still_idle", 0, 0, 0, 0, 0, 0, o_none);
        check_cnt("t5_miss_cnt", miss_count, 16'd0);

        // Saturation near the top of the hit counter.
        force dut.u_hit_cnt.count_q = 16'hFFFE;
        #1;
        release dut.u_hit_cnt.count_q;
        step("t6_hit_a", 0, 1, 0, 1, 0, 0, o_rhit);
        check_cnt("t6_reach_max", hit_count, 16'hFFFF);
        step("t6_hit_b", 0, 1, 0, 1, 0, 0, o_rhit);
        check_cnt("t6_saturate", hit_count, 16'hFFFF);
        // Clear wins over a same-cycle hit and miss-free increment.
        cnt_clear = 1'b1;
        step("t6_hit_clear", 0, 1, 0, 1, 0, 0, o_rhit);
        cnt_clear = 1'b0;
        check_cnt("t6_clear", hit_count, 16'h0);
        step("t6_hit_after", 0, 1, 0, 1, 0, 0, o_rhit);
        check_cnt("t6_count_again", hit_count, 16'd1);
        step("t6_idle", 0, 0, 0, 0, 0, 0, o_none);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
